// File: rtl/hpdmc_initseq_pkg.sv
// Shared constants, types and the bypass command encoder for the HPDMC power-up sequencer.
package hpdmc_initseq_pkg;

  localparam logic [31:0] HPDMC_ADR_SYSCTL = 32'h0000_0000;
  localparam logic [31:0] HPDMC_ADR_BYPASS = 32'h0000_0004;

  localparam logic [31:0] SYSCTL_BYPASS = 32'h0000_0001;
  localparam logic [31:0] SYSCTL_RESET  = 32'h0000_0002;
  localparam logic [31:0] SYSCTL_CKE    = 32'h0000_0004;

  // Low nibble of a bypass word: command strobes driven straight onto the SDRAM pins.
  localparam logic [3:0] CMD_PRE_ALL = 4'hB;
  localparam logic [3:0] CMD_AR      = 4'hD;
  localparam logic [3:0] CMD_LMR     = 4'hF;
  localparam logic [3:0] CMD_LEMR    = 4'hF;

  localparam logic [1:0]  BA_MR       = 2'b00;
  localparam logic [1:0]  BA_EMR      = 2'b01;
  localparam logic [12:0] ADDR_A10    = 13'h0400;
  localparam logic [12:0] MR_DLL_RST  = 13'h0123;
  localparam logic [12:0] MR_NORMAL   = 13'h0023;
  localparam logic [12:0] EMR_VAL     = 13'h0000;

  localparam int unsigned NUM_STEPS = 9;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [7:0]  wait_cyc;
  } step_t;

  typedef enum logic [3:0] {
    StPwrup,
    StIssue,
    StAckWait,
    StGap,
    StFinish,
    StDone,
    StError
`ifdef HPDMC_INITSEQ_READBACK_EN
    ,
    StRead,
    StRdCheck
`endif
  } state_e;

  function automatic logic [31:0] bypass_word(input logic [1:0] ba, input logic [12:0] a,
                                              input logic [3:0] cmd);
    return {13'd0, ba, a, cmd};
  endfunction

  function automatic step_t make_step(input logic [31:0] adr, input logic [31:0] dat,
                                      input logic [7:0] wait_cyc);
    step_t s;
    s.adr      = adr;
    s.dat      = dat;
    s.wait_cyc = wait_cyc;
    return s;
  endfunction

endpackage

// File: rtl/hpdmc_initseq_rom.sv
// Step index to {address, data, post-wait} lookup for the DDR init sequence.
module hpdmc_initseq_rom
  import hpdmc_initseq_pkg::*;
(
  input  logic [3:0] step_idx_i,
  output step_t      step_o
);

  always_comb begin
    step_o = '0;
    case (step_idx_i)
      4'd0: step_o = make_step(HPDMC_ADR_SYSCTL,
                               SYSCTL_BYPASS | SYSCTL_RESET | SYSCTL_CKE, 8'd0);
      4'd1: step_o = make_step(HPDMC_ADR_BYPASS, bypass_word(BA_MR, ADDR_A10, CMD_PRE_ALL), 8'd2);
      4'd2: step_o = make_step(HPDMC_ADR_BYPASS, bypass_word(BA_EMR, EMR_VAL, CMD_LEMR), 8'd2);
      4'd3: step_o = make_step(HPDMC_ADR_BYPASS, bypass_word(BA_MR, MR_DLL_RST, CMD_LMR), 8'd200);
      4'd4: step_o = make_step(HPDMC_ADR_BYPASS, bypass_word(BA_MR, ADDR_A10, CMD_PRE_ALL), 8'd2);
      4'd5: step_o = make_step(HPDMC_ADR_BYPASS, bypass_word(BA_MR, 13'd0, CMD_AR), 8'd8);
      4'd6: step_o = make_step(HPDMC_ADR_BYPASS, bypass_word(BA_MR, 13'd0, CMD_AR), 8'd8);
      4'd7: step_o = make_step(HPDMC_ADR_BYPASS, bypass_word(BA_MR, MR_NORMAL, CMD_LMR), 8'd200);
      4'd8: step_o = make_step(HPDMC_ADR_SYSCTL, SYSCTL_CKE, 8'd0);
      default: step_o = '0;
    endcase
  end

endmodule

// File: rtl/hpdmc_initseq.sv
// Power-up sequencer mastering the HPDMC wbc port through the JEDEC DDR init sequence.
// Define HPDMC_INITSEQ_READBACK_EN to verify SYSCTL by a final read before signalling done.
module hpdmc_initseq
  import hpdmc_initseq_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES = 20000,
  parameter int unsigned ACK_TIMEOUT  = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [31:0] wbc_adr_o,
  output logic [31:0] wbc_dat_o,
  input  logic [31:0] wbc_dat_i,
  output logic        wbc_cyc_o,
  output logic        wbc_stb_o,
  output logic        wbc_we_o,
  input  logic        wbc_ack_i,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned AckW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [23:0]     PwrupLast = 24'(PWRUP_CYCLES - 1);
  localparam logic [AckW-1:0] AckLast   = AckW'(ACK_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [3:0]      step_q, step_d;
  logic [23:0]     pwr_cnt_q, pwr_cnt_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d;
  logic            we_q, we_d, cyc_q, cyc_d;
  logic            busy_q, done_q, error_q;
  logic            step_end, last_step;
  step_t           rom_step;

`ifdef HPDMC_INITSEQ_READBACK_EN
  logic [2:0] rd_q, rd_d;
  logic       unused_dat;
  assign unused_dat = ^wbc_dat_i[31:3];
`else
  logic unused_dat;
  assign unused_dat = ^wbc_dat_i;
`endif

  hpdmc_initseq_rom u_rom (
    .step_idx_i (step_q),
    .step_o     (rom_step)
  );

  assign last_step = (step_q == 4'(NUM_STEPS - 1));

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pwr_cnt_d = pwr_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ack_cnt_d = ack_cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    step_end  = 1'b0;
`ifdef HPDMC_INITSEQ_READBACK_EN
    rd_d      = rd_q;
`endif
    case (state_q)
      StPwrup: begin
        if (pwr_cnt_q == PwrupLast) state_d = StIssue;
        else pwr_cnt_d = pwr_cnt_q + 24'd1;
      end
      StIssue: begin
        adr_d     = rom_step.adr;
        dat_d     = rom_step.dat;
        we_d      = 1'b1;
        cyc_d     = 1'b1;
        ack_cnt_d = '0;
        state_d   = StAckWait;
      end
      StAckWait: begin
        if (wbc_ack_i) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          gap_cnt_d = '0;
          if (rom_step.wait_cyc == 8'd0) step_end = 1'b1;
          else state_d = StGap;
        end else if (ack_cnt_q == AckLast) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StError;
        end else begin
          ack_cnt_d = ack_cnt_q + AckW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == rom_step.wait_cyc - 8'd1) step_end = 1'b1;
        else gap_cnt_d = gap_cnt_q + 8'd1;
      end
      StFinish: begin
`ifdef HPDMC_INITSEQ_READBACK_EN
        adr_d     = HPDMC_ADR_SYSCTL;
        dat_d     = '0;
        we_d      = 1'b0;
        cyc_d     = 1'b1;
        ack_cnt_d = '0;
        state_d   = StRead;
`else
        state_d   = StDone;
`endif
      end
`ifdef HPDMC_INITSEQ_READBACK_EN
      StRead: begin
        if (wbc_ack_i) begin
          cyc_d   = 1'b0;
          rd_d    = wbc_dat_i[2:0];
          state_d = StRdCheck;
        end else if (ack_cnt_q == AckLast) begin
          cyc_d   = 1'b0;
          state_d = StError;
        end else begin
          ack_cnt_d = ack_cnt_q + AckW'(1);
        end
      end
      // Only CKE may remain set once bypass and reset have been released.
      StRdCheck: state_d = (rd_q == 3'b100) ? StDone : StError;
`endif
      StDone, StError: ;
      default: state_d = StError;
    endcase

    if (step_end) begin
      if (last_step) begin
        state_d = StFinish;
      end else begin
        state_d = StIssue;
        step_d  = step_q + 4'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StPwrup;
      step_q    <= '0;
      pwr_cnt_q <= '0;
      gap_cnt_q <= '0;
      ack_cnt_q <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef HPDMC_INITSEQ_READBACK_EN
      rd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      pwr_cnt_q <= pwr_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      busy_q    <= !(state_d inside {StDone, StError});
      done_q    <= (state_d == StDone);
      error_q   <= (state_d == StError);
`ifdef HPDMC_INITSEQ_READBACK_EN
      rd_q      <= rd_d;
`endif
    end
  end

  assign wbc_adr_o = adr_q;
  assign wbc_dat_o = dat_q;
  assign wbc_cyc_o = cyc_q;
  assign wbc_stb_o = cyc_q;
  assign wbc_we_o  = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_hpdmc_initseq.sv
// Directed bench for hpdmc_initseq: step table, ack timing, timeout, mid-run reset, readback.
module tb_hpdmc_initseq;

  localparam int unsigned PWR = 100;
  localparam int unsigned TMO = 16;
`ifdef HPDMC_INITSEQ_READBACK_EN
  localparam int unsigned NCYC = 10;
`else
  localparam int unsigned NCYC = 9;
`endif

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int unsigned w;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] wbc_adr_o, wbc_dat_o;
  logic [31:0] wbc_dat_i = 32'h4;
  logic        wbc_cyc_o, wbc_stb_o, wbc_we_o;
  logic        wbc_ack_i = 1'b0;
  logic        busy, done, error;

  hpdmc_initseq #(
    .PWRUP_CYCLES (PWR),
    .ACK_TIMEOUT  (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .wbc_adr_o (wbc_adr_o),
    .wbc_dat_o (wbc_dat_o),
    .wbc_dat_i (wbc_dat_i),
    .wbc_cyc_o (wbc_cyc_o),
    .wbc_stb_o (wbc_stb_o),
    .wbc_we_o  (wbc_we_o),
    .wbc_ack_i (wbc_ack_i),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned total = 0, bad = 0;
  vec_t        tbl[NCYC];

  // Responder knobs
  int unsigned ack_delay = 1;
  int unsigned no_ack_step = 0;
  logic        stray = 1'b0;

  // Monitor records
  int unsigned edge_n = 0, rel_e = 0, done_e = 0, err_e = 0, unstable = 0, rsp_hold = 0;
  int unsigned rise_e[$], ack_e[$], fall_e[$];
  logic [31:0] rise_adr[$], rise_dat[$];
  logic        rise_we[$];
  logic        cyc_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0, mon_ack = 1'b0;
  logic [31:0] hold_adr, hold_dat;
  logic        hold_we;

  always @(posedge sys_clk) begin
    edge_n  = edge_n + 1;
    mon_ack = wbc_ack_i;
    #1;
    if (cyc_prev && mon_ack) ack_e.push_back(edge_n);
    else if (cyc_prev && !wbc_cyc_o) fall_e.push_back(edge_n);
    if (wbc_cyc_o === 1'b1 && !cyc_prev) begin
      rise_e.push_back(edge_n);
      rise_adr.push_back(wbc_adr_o);
      rise_dat.push_back(wbc_dat_o);
      rise_we.push_back(wbc_we_o);
      hold_adr = wbc_adr_o;
      hold_dat = wbc_dat_o;
      hold_we  = wbc_we_o;
    end else if (wbc_cyc_o === 1'b1) begin
      if (wbc_adr_o !== hold_adr || wbc_dat_o !== hold_dat || wbc_we_o !== hold_we)
        unstable = unstable + 1;
    end
    if (wbc_stb_o !== wbc_cyc_o && !sys_rst) unstable = unstable + 1;
    if (done === 1'b1 && !done_prev) done_e = edge_n;
    if (error === 1'b1 && !err_prev) err_e = edge_n;
    cyc_prev  = (wbc_cyc_o === 1'b1);
    done_prev = (done === 1'b1);
    err_prev  = (error === 1'b1);
    if (cyc_prev) rsp_hold = rsp_hold + 1;
    else rsp_hold = 0;
    wbc_ack_i = (cyc_prev && rsp_hold == ack_delay && rise_e.size() != no_ack_step) ||
                (stray && !cyc_prev);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    rel_e   = edge_n;
    rise_e.delete(); ack_e.delete(); fall_e.delete();
    rise_adr.delete(); rise_dat.delete(); rise_we.delete();
    done_e = 0; err_e = 0; unstable = 0;
  endtask

  task automatic wait_end(input int unsigned budget);
    int unsigned i = 0;
    while (!(done === 1'b1 || error === 1'b1) && i < budget) begin
      @(negedge sys_clk);
      i++;
    end
    if (!(done === 1'b1 || error === 1'b1)) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL wait_end: no done/error within %0d cycles", budget);
    end
  endtask

  task automatic wait_rises(input int unsigned n, input int unsigned budget);
    int unsigned i = 0;
    while (rise_e.size() < n && i < budget) begin
      @(negedge sys_clk);
      i++;
    end
    check("wait_rises", (rise_e.size() >= n), 1);
  endtask

  task automatic check_seq(input string tag, input int unsigned d);
    int unsigned n, exp_rise;
    check({tag, "_ncyc"}, rise_e.size(), NCYC);
    n = rise_e.size();
    if (ack_e.size() < n) n = ack_e.size();
    if (NCYC < n) n = NCYC;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_adr%0d", tag, k), rise_adr[k], tbl[k].adr);
      check($sformatf("%s_dat%0d", tag, k), rise_dat[k], tbl[k].dat);
      check($sformatf("%s_we%0d", tag, k), rise_we[k], tbl[k].we);
      if (k == 0) exp_rise = rel_e + PWR + 1;
      else exp_rise = ack_e[k-1] + 1 + tbl[k-1].w;
      check($sformatf("%s_rise%0d", tag, k), rise_e[k], exp_rise);
      check($sformatf("%s_ack%0d", tag, k), ack_e[k], rise_e[k] + d);
    end
    if (n == NCYC) check({tag, "_done_edge"}, done_e, ack_e[NCYC-1] + 1);
    check({tag, "_stable"}, unstable, 0);
  endtask

  int unsigned dur1;

  initial begin
    tbl[0] = '{32'h0, 32'h0000_0007, 1'b1, 0};
    tbl[1] = '{32'h4, 32'h0000_400B, 1'b1, 2};
    tbl[2] = '{32'h4, 32'h0002_000F, 1'b1, 2};
    tbl[3] = '{32'h4, 32'h0000_123F, 1'b1, 200};
    tbl[4] = '{32'h4, 32'h0000_400B, 1'b1, 2};
    tbl[5] = '{32'h4, 32'h0000_000D, 1'b1, 8};
    tbl[6] = '{32'h4, 32'h0000_000D, 1'b1, 8};
    tbl[7] = '{32'h4, 32'h0000_023F, 1'b1, 200};
    tbl[8] = '{32'h0, 32'h0000_0004, 1'b1, 0};
`ifdef HPDMC_INITSEQ_READBACK_EN
    tbl[9] = '{32'h0, 32'h0000_0000, 1'b0, 0};
`endif

    // Normal sequence, ack one cycle after stb
    do_reset();
    check("reset_ctl", {26'd0, busy, done, error, wbc_cyc_o, wbc_stb_o, wbc_we_o}, 0);
    check("reset_adr", wbc_adr_o, 0);
    check("reset_dat", wbc_dat_o, 0);
    @(negedge sys_clk);
    check("busy_rise", busy, 1);
    wait_end(2000);
    repeat (4) @(negedge sys_clk);
    check_seq("norm", 1);
    check("norm_status", {busy, done, error}, 3'b010);
    dur1 = done_e - rel_e;
    if (ack_e.size() >= 4 && rise_e.size() >= 5) begin
      check("gap_step5", rise_e[4] - ack_e[3], 201);
      check("gap_step3", rise_e[2] - ack_e[1], 3);
    end

    // Delayed ack plus stray acks while idle
    ack_delay = 5;
    stray     = 1'b1;
    do_reset();
    wait_end(2000);
    repeat (4) @(negedge sys_clk);
    stray = 1'b0;
    check_seq("slow", 5);
    check("slow_dur", done_e - rel_e, dur1 + 4 * NCYC);

    // Step 3 never acked
    ack_delay   = 1;
    no_ack_step = 3;
    do_reset();
    wait_end(2000);
    repeat (300) @(negedge sys_clk);
    check("tmo_rises", rise_e.size(), 3);
    check("tmo_falls", fall_e.size(), 1);
    if (fall_e.size() >= 1 && rise_e.size() >= 3) begin
      check("tmo_len", fall_e[0] - rise_e[2], TMO);
      check("tmo_err_edge", err_e, fall_e[0]);
    end
    check("tmo_status", {busy, done, error, wbc_cyc_o, wbc_we_o}, 5'b00100);
    check("tmo_adr", wbc_adr_o, 32'h4);
    check("tmo_dat", wbc_dat_o, 32'h0002_000F);
    no_ack_step = 0;

    // Reset pulse while step 6 waits for ack
    ack_delay = 5;
    do_reset();
    wait_rises(6, 1000);
    do_reset();
    check("mid_rst_ctl", {26'd0, busy, done, error, wbc_cyc_o, wbc_stb_o, wbc_we_o}, 0);
    check("mid_rst_bus", wbc_adr_o | wbc_dat_o, 0);
    wait_rises(1, 300);
    if (rise_e.size() >= 1) begin
      check("restart_edge", rise_e[0], rel_e + PWR + 1);
      check("restart_adr", rise_adr[0], 32'h0);
      check("restart_dat", rise_dat[0], 32'h7);
    end
    wait_end(2000);
    check("restart_done", {busy, done, error}, 3'b010);

`ifdef HPDMC_INITSEQ_READBACK_EN
    // Readback returns a bad SYSCTL value
    ack_delay = 1;
    wbc_dat_i = 32'h7;
    do_reset();
    wait_end(2000);
    repeat (4) @(negedge sys_clk);
    check("rb_bad_status", {busy, done, error}, 3'b001);
    if (ack_e.size() >= NCYC) check("rb_bad_edge", err_e, ack_e[NCYC-1] + 1);
    wbc_dat_i = 32'h4;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
